// File: rtl/seq_divider.sv
// Sequential restoring divider for unsigned N-bit operands.
// One quotient bit is produced per SHIFT/SUB state pair. The A, Q and M
// registers and the controlling FSM all live in this module. All outputs
// are registered, so no input reaches an output combinationally.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SUB,
    DONE
  } state_t;

  state_t          state;
  logic [N:0]      a;
  logic [N-1:0]    q;
  logic [N-1:0]    m;
  logic [CW-1:0]   count;

  logic [N:0]      trial;
  logic [N:0]      next_a;
  logic [N-1:0]    next_q;

  // Trial subtract. A negative result (sign bit set) means the divisor
  // did not fit: keep A as it was and shift a 0 into the quotient.
  always_comb begin
    trial  = a - {1'b0, m};
    next_a = trial[N] ? a : trial;
    next_q = {q[N-1:1], ~trial[N]};
  end

  // Controller and datapath. Result registers are updated only when the
  // FSM enters DONE, so partial quotients never become visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              a           <= '0;
              q           <= dividend;
              m           <= divisor;
              count       <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= SHIFT;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end

        SHIFT: begin
          {a, q} <= {a[N-1:0], q, 1'b0};
          state  <= SUB;
        end

        SUB: begin
          a <= next_a;
          q <= next_q;
          if (count == LAST) begin
            quotient  <= next_q;
            remainder <= next_a[N-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + 1'b1;
            state <= SHIFT;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): a directed vector table,
// hand-written abort and ignored-start sequences, randomized operands
// and an exhaustive back-to-back sweep, all scored against plain
// integer division.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] held_q = '0;
  logic [N-1:0] held_r = '0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    bit           dbz;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural reference: plain integer division.
  function automatic void refDivide(input int a, input int b, output int q, output int r, output bit dbz);
    if (b == 0) begin
      q = (1 << N) - 1;
      r = a;
      dbz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      dbz = 1'b0;
    end
  endfunction

  // Drive one request from a falling edge and follow it until Done,
  // then one more cycle to confirm the pulse is a single cycle wide.
  // With noise set, stray Start pulses and junk operands are driven
  // while the divider is busy or signalling done.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise,
                               output int lat, output bit seen, output bit busy_seen,
                               output bit held_ok, output bit pulse_ok);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    lat       = 0;
    seen      = 1'b0;
    busy_seen = 1'b0;
    held_ok   = 1'b1;
    pulse_ok  = 1'b1;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (done) seen = 1'b1;
      else if (quotient !== held_q || remainder !== held_r) held_ok = 1'b0;
      if (noise && (busy || done)) begin
        start    = 1'($urandom_range(0, 1));
        dividend = N'($urandom);
        divisor  = N'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (seen) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulse_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  // Run one division and score every observable against expectations.
  task automatic runCase(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input bit edbz, input int elat, input bit noise);
    int lat;
    bit seen, busy_seen, held_ok, pulse_ok;
    applyStimulus(a, b, noise, lat, seen, busy_seen, held_ok, pulse_ok);
    checkOutput($sformatf("done_seen %0d/%0d", a, b), 32'(seen), 32'd1);
    checkOutput($sformatf("latency %0d/%0d", a, b), 32'(lat), 32'(elat));
    checkOutput($sformatf("quotient %0d/%0d", a, b), 32'(quotient), 32'(eq));
    checkOutput($sformatf("remainder %0d/%0d", a, b), 32'(remainder), 32'(er));
    checkOutput($sformatf("div_by_zero %0d/%0d", a, b), 32'(div_by_zero), 32'(edbz));
    checkOutput($sformatf("done_pulse %0d/%0d", a, b), 32'(pulse_ok), 32'd1);
    checkOutput($sformatf("held_result %0d/%0d", a, b), 32'(held_ok), 32'd1);
    checkOutput($sformatf("busy_seen %0d/%0d", a, b), 32'(busy_seen), 32'(!edbz));
    if (b != '0) begin
      checkOutput($sformatf("invariant %0d/%0d", a, b),
                  32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
      checkOutput($sformatf("rem_lt_div %0d/%0d", a, b), 32'(remainder < b), 32'd1);
    end
    held_q = eq;
    held_r = er;
  endtask

  // Model-driven wrapper for randomized and exhaustive operands.
  task automatic runModel(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise);
    int q, r;
    bit dbz;
    refDivide(int'(a), int'(b), q, r, dbz);
    runCase(a, b, N'(q), N'(r), dbz, dbz ? 1 : 2 * N + 1, noise);
  endtask

  // Main test sequence.
  initial begin
    bit done_after_abort;

    vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dbz: 1'b0, lat: 9};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0, lat: 9};
    vecs[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dbz: 1'b0, lat: 9};
    vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0, lat: 9};
    vecs[4] = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9, dbz: 1'b1, lat: 1};
    vecs[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0, lat: 9};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++)
      runCase(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, 1'b0);

    $display("[TB] stray start pulses while busy and done");
    runCase(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 9, 1'b1);
    runCase(4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1, 1'b1);
    runCase(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 9, 1'b1);

    $display("[TB] reset in the middle of 12/5");
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort quotient", 32'(quotient), 32'd0);
    checkOutput("abort remainder", 32'(remainder), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    held_q = '0;
    held_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_after_abort = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_after_abort = 1'b1;
    end
    checkOutput("no done after abort", 32'(done_after_abort), 32'd0);
    runCase(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 9, 1'b0);

    $display("[TB] randomized operands");
    for (int i = 0; i < 60; i++)
      runModel(N'($urandom), N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("[TB] exhaustive back-to-back sweep");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        runModel(N'(a), N'(b), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
